// File: rtl/bmem_dump_tx.sv
// bmem_dump_tx: reads one full BMEM block and streams it out over a UART
// write-lock slot. The frame is byte-identical to a loader BMEM write frame,
// so looping the stream back into the loader re-creates the block:
//   0x80, address bytes LSB-first, then every word (word 0 first) LSB-first.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   dump_req/dump_addr  one-cycle start pulse and block address to dump
//   busy, done          in-progress flag, one-cycle completion pulse
//   bmem_read_addr/data BMEM read port (word i at [i*BITWIDTH +: BITWIDTH])
//   write_lock_req/res  UART write lock request / grant
//   write_ready         UART accepts a byte this cycle
//   write_data/_valid   byte to transmit and its valid
module bmem_dump_tx #(
  parameter int BITWIDTH     = 32,
  parameter int MESHUNITS    = 2,
  parameter int TILEUNITS    = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                dump_req,
  input  logic [BITWIDTH-1:0] dump_addr,
  output logic                busy,
  output logic                done,
  output logic [BITWIDTH-1:0] bmem_read_addr,
  input  logic [MESHUNITS*MESHUNITS*TILEUNITS*TILEUNITS*BITWIDTH-1:0] bmem_read_data,
  output logic                write_lock_req,
  input  logic                write_lock_res,
  input  logic                write_ready,
  output logic [7:0]          write_data,
  output logic                write_data_valid
);

  localparam int BYTES = BITWIDTH / 8;
  localparam int WORDS = MESHUNITS * MESHUNITS * TILEUNITS * TILEUNITS;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [BCW-1:0] BYTE_LAST = BCW'(BYTES - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(WORDS - 1);
  localparam logic [2:0]     LAT_LAST  = 3'(READ_LATENCY);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_LOCK = 3'd2;
  localparam logic [2:0] S_HDR  = 3'd3;
  localparam logic [2:0] S_ADDR = 3'd4;
  localparam logic [2:0] S_DATA = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]                state;
  logic [2:0]                lat_ctr;
  logic [BCW-1:0]            byte_ctr;
  logic [WCW-1:0]            word_ctr;
  logic [WORDS*BITWIDTH-1:0] buffer;
  logic                      accept;
  logic                      snap;

  assign accept = write_data_valid & write_ready & write_lock_res;
  // Read data is valid for the cycle that begins READ_LATENCY edges after the
  // address appears; it is captured at the end of that cycle.
  assign snap   = (state == S_READ) && (lat_ctr == LAT_LAST);

  // Control path: state, counters and the latched address
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      lat_ctr        <= '0;
      byte_ctr       <= '0;
      word_ctr       <= '0;
      bmem_read_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dump_req) begin
            bmem_read_addr <= dump_addr;
            lat_ctr        <= '0;
            state          <= S_READ;
          end
        end
        S_READ: begin
          if (snap) state <= S_LOCK;
          else      lat_ctr <= lat_ctr + 3'd1;
        end
        S_LOCK: begin
          if (write_lock_res) state <= S_HDR;
        end
        S_HDR: begin
          if (accept) begin
            byte_ctr <= '0;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (accept) begin
            if (byte_ctr == BYTE_LAST) begin
              byte_ctr <= '0;
              word_ctr <= '0;
              state    <= S_DATA;
            end else begin
              byte_ctr <= byte_ctr + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            if (byte_ctr == BYTE_LAST) begin
              byte_ctr <= '0;
              if (word_ctr == WORD_LAST) state <= S_DONE;
              else                       word_ctr <= word_ctr + 1'b1;
            end else begin
              byte_ctr <= byte_ctr + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Snapshot of the block; later BMEM changes never reach the frame
  always_ff @(posedge clock) begin
    if (snap) buffer <= bmem_read_data;
  end

  // Outputs decode straight from state, so a lock drop or write_ready stall
  // leaves the counters, and therefore write_data, untouched.
  always_comb begin
    busy             = (state != S_IDLE) && (state != S_DONE);
    done             = (state == S_DONE);
    write_data_valid = (state == S_HDR) || (state == S_ADDR) || (state == S_DATA);
    write_lock_req   = write_data_valid || (state == S_LOCK);
    write_data       = 8'h00;
    case (state)
      S_HDR:   write_data = 8'b10_000000;
      S_ADDR:  write_data = bmem_read_addr[8*int'(byte_ctr) +: 8];
      S_DATA:  write_data = buffer[int'(word_ctr)*BITWIDTH + 8*int'(byte_ctr) +: 8];
      default: write_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_bmem_dump_tx.sv
// Testbench for bmem_dump_tx: two instances (READ_LATENCY 1 and 3) share the
// UART-side inputs; a behavioural BMEM and a frame model built from the
// framing rules supply every expected byte.
module tb_bmem_dump_tx;
  localparam int BW    = 32;
  localparam int BYTES = 4;
  localparam int WORDS = 16;
  localparam int NB    = 1 + BYTES + WORDS * BYTES;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, write_lock_res, write_ready, dump_req1, dump_req3;
  logic [BW-1:0] dump_addr;
  logic busy1, done1, lreq1, wv1, busy3, done3, lreq3, wv3;
  logic [7:0] wd1, wd3;
  logic [BW-1:0] ra1, ra3;
  logic [WORDS*BW-1:0] rd1, rd3;

  bmem_dump_tx #(.BITWIDTH(32), .MESHUNITS(2), .TILEUNITS(2), .READ_LATENCY(1)) dut (
    .clock(clock), .reset(reset), .dump_req(dump_req1), .dump_addr(dump_addr),
    .busy(busy1), .done(done1), .bmem_read_addr(ra1), .bmem_read_data(rd1),
    .write_lock_req(lreq1), .write_lock_res(write_lock_res), .write_ready(write_ready),
    .write_data(wd1), .write_data_valid(wv1));

  bmem_dump_tx #(.BITWIDTH(32), .MESHUNITS(2), .TILEUNITS(2), .READ_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .dump_req(dump_req3), .dump_addr(dump_addr),
    .busy(busy3), .done(done3), .bmem_read_addr(ra3), .bmem_read_data(rd3),
    .write_lock_req(lreq3), .write_lock_res(write_lock_res), .write_ready(write_ready),
    .write_data(wd3), .write_data_valid(wv3));

  // Behavioural BMEM: a block per address, delivered READ_LATENCY cycles later
  logic [WORDS*BW-1:0] mem [logic [BW-1:0]];

  function automatic logic [WORDS*BW-1:0] lookup(input logic [BW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  logic [WORDS*BW-1:0] p1;
  logic [WORDS*BW-1:0] p3 [3];
  always @(posedge clock) begin
    p1    <= lookup(ra1);
    p3[0] <= lookup(ra3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rd1 = p1;
  assign rd3 = p3[2];

  // Selected instance view
  logic sel;
  logic busy_m, done_m, lreq_m, wv_m;
  logic [7:0] wd_m;
  logic [BW-1:0] ra_m;
  assign busy_m = sel ? busy3 : busy1;
  assign done_m = sel ? done3 : done1;
  assign lreq_m = sel ? lreq3 : lreq1;
  assign wv_m   = sel ? wv3   : wv1;
  assign wd_m   = sel ? wd3   : wd1;
  assign ra_m   = sel ? ra3   : ra1;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Frame model: header, address LSB-first, words in order each LSB-first
  function automatic void build(input logic [BW-1:0] a, input logic [WORDS*BW-1:0] blk);
    logic [BW-1:0] w;
    exp_q.delete();
    exp_q.push_back(8'h80);
    for (int b = 0; b < BYTES; b++) exp_q.push_back(a[8*b +: 8]);
    for (int i = 0; i < WORDS; i++) begin
      w = blk[i*BW +: BW];
      for (int b = 0; b < BYTES; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endfunction

  function automatic void fill_pattern(input logic [BW-1:0] a);
    logic [WORDS*BW-1:0] blk;
    for (int i = 0; i < WORDS; i++) blk[i*BW +: BW] = 32'hA0B0C000 + i;
    mem[a] = blk;
  endfunction

  function automatic void fill_random(input logic [BW-1:0] a);
    logic [WORDS*BW-1:0] blk;
    for (int i = 0; i < WORDS; i++) blk[i*BW +: BW] = $urandom;
    mem[a] = blk;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy_m, 0);
    chk({tag, "_done"}, done_m, 0);
    chk({tag, "_lreq"}, lreq_m, 0);
    chk({tag, "_wv"}, wv_m, 0);
    chk({tag, "_wd"}, wd_m, 0);
    chk({tag, "_raddr"}, ra_m, 0);
  endtask

  // mode: 0 ready always, 1 ready every other cycle, 2 random ready
  task automatic run_dump(input bit s, input logic [BW-1:0] a, input int grant_dly,
                          input int mode, input int drop_at, input int reset_at,
                          input int req_again_at, input bit rewrite);
    logic [WORDS*BW-1:0] blk;
    logic [7:0] pd;
    int nacc = 0, lreq_cyc = 0, drop_left = 0, dones = 0;
    bit pend = 0, stable_ok = 1, early_ok = 1, granted = 0;
    bit dropped = 0, req2 = 0, req_sent = 0, rewrote = 0;
    blk = lookup(a);
    build(a, blk);
    sel = s;
    @(negedge clock);
    write_lock_res = 0; write_ready = 0; dump_addr = a;
    if (s) dump_req3 = 1; else dump_req1 = 1;
    @(negedge clock);
    dump_req1 = 0; dump_req3 = 0;
    chk("busy_after_req", busy_m, 1);
    chk("read_addr", ra_m, a);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (req2) begin dump_req1 = 0; dump_req3 = 0; dump_addr = a; req2 = 0; end
      if (done_m) begin dones++; break; end
      if (reset_at >= 0 && nacc == reset_at) begin
        reset = 1; write_lock_res = 0; write_ready = 0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        chk("midreset_no_done", done_m, 0);
        chk("midreset_idle", busy_m, 0);
        return;
      end
      if (req_again_at >= 0 && nacc == req_again_at && !req_sent) begin
        dump_addr = 32'h5555_0000;
        if (s) dump_req3 = 1; else dump_req1 = 1;
        req2 = 1; req_sent = 1;
      end
      if (lreq_m) lreq_cyc++;
      if (rewrite && lreq_m && !rewrote) begin mem[a] = '1; rewrote = 1; end
      if (drop_at >= 0 && !dropped && nacc == drop_at) begin drop_left = 5; dropped = 1; end
      write_lock_res = lreq_m && (lreq_cyc > grant_dly) && (drop_left == 0);
      if (drop_left > 0) drop_left--;
      case (mode)
        0:       write_ready = 1;
        1:       write_ready = cyc[0];
        default: write_ready = 1'($urandom_range(0, 1));
      endcase
      if (wv_m && !granted) early_ok = 0;
      if (pend && wv_m && wd_m !== pd) stable_ok = 0;
      if (wv_m && write_ready && write_lock_res) begin
        if (nacc < NB) chk($sformatf("byte%0d", nacc), wd_m, exp_q[nacc]);
        else chk("extra_byte", nacc, NB - 1);
        nacc++;
        pend = 0;
      end else begin
        pend = wv_m; pd = wd_m;
      end
      if (write_lock_res) granted = 1;
      @(negedge clock);
    end
    chk("done_seen", dones, 1);
    chk("byte_count", nacc, NB);
    chk("stable_while_stalled", stable_ok, 1);
    chk("no_valid_before_grant", early_ok, 1);
    chk("done_lreq_low", lreq_m, 0);
    write_lock_res = 0; write_ready = 0;
    @(negedge clock);
    chk("done_single_pulse", done_m, 0);
    chk("busy_low_after_done", busy_m, 0);
  endtask

  initial begin
    sel = 0; reset = 1; write_lock_res = 0; write_ready = 0;
    dump_req1 = 0; dump_req3 = 0; dump_addr = '0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset1");
    sel = 1;
    check_idle_outputs("reset3");
    reset = 0;
    @(negedge clock);
    sel = 0;
    chk("idle_after_reset", busy_m, 0);

    fill_pattern(32'h10);
    run_dump(0, 32'h10, 0, 0, -1, -1, -1, 0);   // basic
    run_dump(0, 32'h10, 20, 1, -1, -1, -1, 0);  // backpressure + late grant
    run_dump(0, 32'h10, 2, 0, -1, -1, -1, 1);   // snapshot
    fill_pattern(32'h10);
    run_dump(0, 32'h10, 0, 0, 30, -1, -1, 0);   // lock loss
    fill_random(32'h20);
    run_dump(0, 32'h10, 0, 0, -1, 12, -1, 0);   // reset mid-frame
    run_dump(0, 32'h20, 0, 0, -1, -1, -1, 0);   // fresh frame after abort
    run_dump(0, 32'h10, 0, 0, -1, -1, 5, 0);    // dump_req while busy
    fill_random(32'hFFFF_FFFF);
    run_dump(1, 32'hFFFF_FFFF, 3, 0, -1, -1, -1, 0);  // READ_LATENCY=3
    run_dump(1, 32'hFFFF_FFFF, 0, 2, 40, -1, -1, 1);
    for (int r = 0; r < 4; r++) begin
      logic [BW-1:0] ra;
      ra = $urandom;
      fill_random(ra);
      run_dump(1'(r), ra, $urandom_range(0, 10), 2, -1, -1, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
